bus_driver_arbiter: RTL and testbench

- Round-robin arbiter sharing one tristate neuron-output bus (DATA_W = 21 bits) among N_REQ requesters.
- Produces one-hot registered grant lines that directly drive the control inputs of each requester's tristate buffer.
- Guarantees at most one driver at any time and a turnaround gap between owners, so drivers never contend.
- Enforces a maximum hold time per owner.

---
 rtl/bus_driver_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_driver_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bus_driver_arbiter.sv
// Round-robin owner selection for a shared tristate output bus. Grants are
// registered one-hot enables with a forced dead gap after every release.
module bus_driver_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int MAX_HOLD  = 8,
  parameter  int TA_CYCLES = 1,
  localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             bus_busy,
  output logic             timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam int TA_W   = $clog2(TA_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [TA_W-1:0]    ta_cnt, ta_n;
  logic [N_REQ-1:0]   grant_n;
  logic [IDX_W-1:0]   idx_n;
  logic               busy_n;
  logic               timeout_n;
  logic [IDX_W-1:0]   sel;
  logic               any_req;
  logic               own_req;
  logic               own_done;
  logic               hold_max;
  logic               release_bus;
  logic               ta_last;

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    sel     = ptr;
    any_req = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_req && req[wrap_idx(int'(ptr), i)]) begin
        sel     = wrap_idx(int'(ptr), i);
        any_req = 1'b1;
      end
    end
  end

  // grant is one-hot, so masking avoids indexing by the owner number.
  assign own_req     = |(req & grant);
  assign own_done    = |(done & grant);
  assign hold_max    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_bus = own_done | ~own_req | hold_max;
  assign ta_last     = (ta_cnt == TA_W'(TA_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      ta_cnt    <= '0;
      grant     <= '0;
      grant_idx <= '0;
      bus_busy  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      ta_cnt    <= ta_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      bus_busy  <= busy_n;
      timeout   <= timeout_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (any_req) state_n = GRANT;
      GRANT:      if (release_bus) state_n = TURNAROUND;
      TURNAROUND: if (ta_last) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // A timeout is flagged only when the hold limit alone forced the release.
  always_comb begin
    grant_n   = grant;
    idx_n     = grant_idx;
    busy_n    = bus_busy;
    timeout_n = 1'b0;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    ta_n      = ta_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_n      = '0;
          grant_n[sel] = 1'b1;
          idx_n        = sel;
          busy_n       = 1'b1;
          hold_n       = '0;
        end
      end
      GRANT: begin
        hold_n = hold_cnt + 1'b1;
        if (release_bus) begin
          grant_n   = '0;
          idx_n     = '0;
          busy_n    = 1'b0;
          ta_n      = '0;
          timeout_n = hold_max & ~own_done & own_req;
          ptr_n     = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      TURNAROUND: begin
        if (!ta_last) ta_n = ta_cnt + 1'b1;
      end
      default: begin
        grant_n = '0;
        idx_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_driver_arbiter.sv
// Directed bench for bus_driver_arbiter with N_REQ=4, MAX_HOLD=8, TA_CYCLES=1;
// outputs are sampled 1ns after the rising edge, inputs driven at the same point.
module tb_bus_driver_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       bus_busy;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;
  int rr_seq[5]   = '{0, 1, 2, 3, 0};

  bus_driver_arbiter #(
    .N_REQ(4),
    .MAX_HOLD(8),
    .TA_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_idx(grant_idx),
    .bus_busy(bus_busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic expectBus(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic busy, input logic to);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
    checkOutput({tag, ".grant_idx"}, 32'(grant_idx), 32'(idx));
    checkOutput({tag, ".bus_busy"}, 32'(bus_busy), 32'(busy));
    checkOutput({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    req  = r;
    done = d;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    step();
    expectBus("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  // Never more than one tristate enable at any falling edge.
  always @(negedge clk) begin
    checkOutput("onehot0", 32'($onehot0(grant)), 32'd1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;

    // Single requester, released by done.
    applyReset();
    applyStimulus(4'b0001, 4'b0000);
    step(); expectBus("t1_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(); expectBus("t1_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(); expectBus("t1_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(); expectBus("t1_c4", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0001);
    step(); expectBus("t1_c5", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    step(); expectBus("t1_c6", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Round robin, each owner holds for two cycles then pulses done.
    applyReset();
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step(); expectBus("t2_own_a", 4'(1 << rr_seq[k]), 2'(rr_seq[k]), 1'b1, 1'b0);
      step(); expectBus("t2_own_b", 4'(1 << rr_seq[k]), 2'(rr_seq[k]), 1'b1, 1'b0);
      applyStimulus(4'b1111, 4'(1 << rr_seq[k]));
      step(); expectBus("t2_gap1", 4'b0000, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b1111, 4'b0000);
      step(); expectBus("t2_gap2", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Hold limit: eight cycles, timeout pulse, regrant after wrap.
    applyReset();
    applyStimulus(4'b0100, 4'b0000);
    for (int c = 0; c < 8; c++) begin
      step(); expectBus("t3_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(); expectBus("t3_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    step(); expectBus("t3_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); expectBus("t3_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    step(); expectBus("t3_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Non-owner done ignored; owner released by dropping req.
    applyReset();
    applyStimulus(4'b0010, 4'b0000);
    step(); expectBus("t4_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b1000);
    step(); expectBus("t4_foreign_done", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b0000);
    step(); expectBus("t4_still", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    step(); expectBus("t4_req_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); expectBus("t4_gap", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then pointer restarts at 0.
    applyReset();
    applyStimulus(4'b0010, 4'b0000);
    step(); expectBus("t5_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 expectBus("t5_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 4'b0000);
    step(); expectBus("t5_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(); expectBus("t5_post", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    step(); expectBus("t5_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    // done coinciding with the last allowed cycle: no timeout.
    applyReset();
    applyStimulus(4'b1000, 4'b0000);
    for (int c = 1; c < 8; c++) begin
      step(); expectBus("t6_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    step(); expectBus("t6_last", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b1000, 4'b1000);
    step(); expectBus("t6_done_at_max", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    step(); expectBus("t6_gap", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
